// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- single-issue instruction fetch stage with IF/ID register.
//
// Holds a 7-bit word PC, presents it combinationally to instruction memory,
// and registers the returned word together with its address for decode.
// Jumps (opcode 6'b000010, target in bits[6:0]) are resolved in this stage
// with no bubble. Downstream branches redirect the PC and flush IF/ID.
//
// Optional feature (macro FETCH_HALT_DETECT_EN): a jump to its own address
// stops fetch and raises halted until reset or a taken branch. Without the
// macro, halted is constant 0 and a self-jump simply refetches forever.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   imem_addr    out  [6:0]  word address to instruction memory (= PC)
//   imem_instr   in   [31:0] instruction word for imem_addr
//   stall        in   hold PC and IF/ID register
//   br_taken     in   redirect to br_target and flush IF/ID
//   br_target    in   [6:0]  branch destination word address
//   if_instr     out  [31:0] registered instruction to decode
//   if_pc        out  [6:0]  registered address of if_instr
//   if_pc_plus1  out  [6:0]  registered if_pc + 1 (mod 128)
//   if_valid     out  if_instr is a real fetched instruction
//   halted       out  fetch stopped on self-jump
// ---------------------------------------------------------------------------
module fetch_unit (
    input  logic        clk,
    input  logic        reset_n,
    output logic [6:0]  imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [6:0]  br_target,
    output logic [31:0] if_instr,
    output logic [6:0]  if_pc,
    output logic [6:0]  if_pc_plus1,
    output logic        if_valid,
    output logic        halted
);

    localparam logic [5:0] OP_JUMP = 6'b000010;

    logic [6:0]  pc;
    logic [6:0]  pc_nxt;
    logic [6:0]  pc_inc;
    logic [6:0]  jump_target;
    logic        is_jump;
    logic [31:0] instr_nxt;
    logic [6:0]  ifpc_nxt;
    logic [6:0]  ifpc1_nxt;
    logic        valid_nxt;
    logic        halt_now;

    // Address bits between opcode and target carry no meaning for fetch.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^imem_instr[25:7];

    assign imem_addr   = pc;
    assign pc_inc      = pc + 7'd1;
    assign is_jump     = (imem_instr[31:26] == OP_JUMP);
    assign jump_target = imem_instr[6:0];

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic {
        S_RUN,
        S_HALT
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign halt_now = (state == S_HALT);
`else
    assign halt_now = 1'b0;
`endif

    assign halted = halt_now;

    // Priority: br_taken > halted > stall > jump > sequential.
    always_comb begin
        pc_nxt    = pc;
        instr_nxt = if_instr;
        ifpc_nxt  = if_pc;
        ifpc1_nxt = if_pc_plus1;
        valid_nxt = if_valid;
`ifdef FETCH_HALT_DETECT_EN
        state_nxt = state;
`endif
        if (br_taken) begin
            // Flush IF/ID but keep its address fields.
            pc_nxt    = br_target;
            instr_nxt = '0;
            valid_nxt = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            state_nxt = S_RUN;
`endif
        end else if (halt_now) begin
            instr_nxt = '0;
            valid_nxt = 1'b0;
        end else if (!stall) begin
            instr_nxt = imem_instr;
            ifpc_nxt  = pc;
            ifpc1_nxt = pc_inc;
            valid_nxt = 1'b1;
            if (is_jump) begin
                pc_nxt = jump_target;
`ifdef FETCH_HALT_DETECT_EN
                if (jump_target == pc) begin
                    state_nxt = S_HALT;
                end
`endif
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= '0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
            if_valid    <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            if_instr    <= instr_nxt;
            if_pc       <= ifpc_nxt;
            if_pc_plus1 <= ifpc1_nxt;
            if_valid    <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A table of per-cycle {inputs, expected outputs} rows is pushed through a
// scoreboard queue; hand-written sequences cover asynchronous reset while
// halted and mid-jump. Honours FETCH_HALT_DETECT_EN for halt expectations.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [6:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        br_taken;
    logic [6:0]  br_target;
    logic [31:0] if_instr;
    logic [6:0]  if_pc;
    logic [6:0]  if_pc_plus1;
    logic        if_valid;
    logic        halted;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit H = 1'b1;
`else
    localparam bit H = 1'b0;
`endif

    typedef struct {
        logic       stall;
        logic       br;
        logic [6:0] tgt;
        logic [6:0] pc;
        logic [6:0] p1;
        logic       valid;
        logic [6:0] addr;
        logic       halt;
    } row_t;

    row_t tbl[$];
    row_t sb[$];

    logic [31:0] mem [128];
    int checks   = 0;
    int failures = 0;

    assign imem_instr = mem[imem_addr];

    fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus1 (if_pc_plus1),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input logic s, input logic b, input logic [6:0] t,
                                input logic [6:0] pc, input logic [6:0] p1,
                                input logic v, input logic [6:0] a, input logic h);
        row_t r;
        r.stall = s; r.br = b; r.tgt = t; r.pc = pc; r.p1 = p1;
        r.valid = v; r.addr = a; r.halt = h;
        tbl.push_back(r);
    endfunction

    function automatic row_t mk(input logic s, input logic b, input logic [6:0] t,
                                input logic [6:0] pc, input logic [6:0] p1,
                                input logic v, input logic [6:0] a, input logic h);
        row_t r;
        r.stall = s; r.br = b; r.tgt = t; r.pc = pc; r.p1 = p1;
        r.valid = v; r.addr = a; r.halt = h;
        return r;
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic run_row(input string tag, input row_t r);
        row_t e;
        logic [31:0] exp_instr;
        stall     = r.stall;
        br_taken  = r.br;
        br_target = r.tgt;
        sb.push_back(r);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        exp_instr = e.valid ? mem[e.pc] : 32'h0;
        chk({tag, " if_pc"},       {25'h0, if_pc},       {25'h0, e.pc});
        chk({tag, " if_pc_plus1"}, {25'h0, if_pc_plus1}, {25'h0, e.p1});
        chk({tag, " if_valid"},    {31'h0, if_valid},    {31'h0, e.valid});
        chk({tag, " imem_addr"},   {25'h0, imem_addr},   {25'h0, e.addr});
        chk({tag, " if_instr"},    if_instr,             exp_instr);
        chk({tag, " halted"},      {31'h0, halted},      {31'h0, e.halt});
        stall    = 1'b0;
        br_taken = 1'b0;
    endtask

    // Assert reset mid-cycle and confirm outputs clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        chk({tag, " rst if_pc"},       {25'h0, if_pc},       32'h0);
        chk({tag, " rst if_pc_plus1"}, {25'h0, if_pc_plus1}, 32'h0);
        chk({tag, " rst if_valid"},    {31'h0, if_valid},    32'h0);
        chk({tag, " rst if_instr"},    if_instr,             32'h0);
        chk({tag, " rst imem_addr"},   {25'h0, imem_addr},   32'h0);
        chk({tag, " rst halted"},      {31'h0, halted},      32'h0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [6:0] a7;
        reset_n   = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;

        for (int unsigned a = 0; a < 128; a++) begin
            a7 = 7'(a);
            mem[a] = {6'b001000, 3'b000, a7, 9'h000, a7};
        end
        mem[0]  = 32'h0000_0000;                  // nop
        mem[1]  = 32'h2001_0001;                  // addi
        mem[2]  = 32'h8c02_0000;                  // lw
        mem[3]  = 32'h8c03_0004;                  // lw
        mem[12] = {6'b000010, 19'h5a5a5, 7'd19};  // j 19, junk in ignored bits
        mem[38] = {6'b000010, 19'h0, 7'd38};      // j 38 (self-jump)

        //   stall br tgt   pc   p1  v  addr halt
        add(0, 0, 0,    0,   1, 1, 1,   0);
        add(0, 0, 0,    1,   2, 1, 2,   0);
        add(0, 0, 0,    2,   3, 1, 3,   0);
        add(0, 0, 0,    3,   4, 1, 4,   0);
        add(0, 0, 0,    4,   5, 1, 5,   0);
        add(0, 0, 0,    5,   6, 1, 6,   0);
        add(1, 0, 0,    5,   6, 1, 6,   0);
        add(1, 0, 0,    5,   6, 1, 6,   0);
        add(1, 0, 0,    5,   6, 1, 6,   0);
        add(0, 0, 0,    6,   7, 1, 7,   0);
        add(0, 0, 0,    7,   8, 1, 8,   0);
        add(0, 0, 0,    8,   9, 1, 9,   0);
        add(0, 0, 0,    9,  10, 1, 10,  0);
        add(0, 0, 0,    10, 11, 1, 11,  0);
        add(0, 0, 0,    11, 12, 1, 12,  0);
        add(0, 0, 0,    12, 13, 1, 19,  0);
        add(0, 0, 0,    19, 20, 1, 20,  0);
        add(0, 0, 0,    20, 21, 1, 21,  0);
        add(1, 1, 13,   20, 21, 0, 13,  0);
        add(0, 0, 0,    13, 14, 1, 14,  0);
        add(0, 1, 126,  13, 14, 0, 126, 0);
        add(0, 0, 0,    126, 127, 1, 127, 0);
        add(0, 0, 0,    127, 0,  1, 0,  0);
        add(0, 0, 0,    0,   1,  1, 1,  0);
        add(0, 1, 38,   0,   1,  0, 38, 0);
        add(0, 0, 0,    38,  39, 1, 38, H);
        add(0, 0, 0,    38,  39, !H, 38, H);
        add(0, 0, 0,    38,  39, !H, 38, H);
        add(1, 0, 0,    38,  39, !H, 38, H);
        add(0, 1, 2,    38,  39, 0,  2,  0);
        add(0, 0, 0,    2,   3,  1,  3,  0);

        #2;
        chk("reset if_pc",       {25'h0, if_pc},       32'h0);
        chk("reset if_pc_plus1", {25'h0, if_pc_plus1}, 32'h0);
        chk("reset if_valid",    {31'h0, if_valid},    32'h0);
        chk("reset if_instr",    if_instr,             32'h0);
        chk("reset imem_addr",   {25'h0, imem_addr},   32'h0);
        chk("reset halted",      {31'h0, halted},      32'h0);
        #10;
        reset_n = 1'b1;   // released at t=12 with clk low; first edge at t=15

        for (int i = 0; i < tbl.size(); i++) begin
            run_row($sformatf("row%0d", i), tbl[i]);
        end

        // Reset while (possibly) halted: no redirect survives, fetch restarts at 0.
        run_row("hs0", mk(0, 1, 38, 2,  3,  0, 38, 0));
        run_row("hs1", mk(0, 0, 0,  38, 39, 1, 38, H));
        async_reset("halt");
        run_row("hs2", mk(0, 0, 0,  0,  1,  1, 1,  0));

        // Reset immediately after a jump is fetched: its target is discarded.
        run_row("js0", mk(0, 1, 12, 0,  1,  0, 12, 0));
        run_row("js1", mk(0, 0, 0,  12, 13, 1, 19, 0));
        async_reset("jump");
        run_row("js2", mk(0, 0, 0,  0,  1,  1, 1,  0));

        // Reset during stall: held state is dropped.
        run_row("ss0", mk(0, 0, 0,  1,  2,  1, 2,  0));
        stall = 1'b1;
        async_reset("stall");
        run_row("ss1", mk(1, 0, 0,  0,  0,  0, 0,  0));
        run_row("ss2", mk(0, 0, 0,  0,  1,  1, 1,  0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide: imem_addr  output  7  word address to instruction memory, combinational copy of PC.
REQ-004 SHALL provide: imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-005 SHALL provide: stall  input  1  downstream hazard; hold PC and IF/ID register.
REQ-006 SHALL provide: br_taken  input  1  downstream resolved branch; redirect and flush.
REQ-007 SHALL provide: br_target  input  7  absolute word address of branch destination.
REQ-008 SHALL provide: if_instr  output  32  registered instruction to decode.
REQ-009 SHALL provide: if_pc  output  7  registered address of if_instr.
REQ-010 SHALL provide: if_pc_plus1  output  7  registered if_pc+1, modulo 128.
REQ-011 SHALL provide: if_valid  output  1  if_instr is a real fetched instruction.
REQ-012 SHALL provide: halted  output  1  fetch stopped on self-jump (config-dependent).

Function
REQ-013 SHALL hold a 7-bit PC register; imem_addr = PC with zero added latency.
REQ-014 SHALL classify imem_instr as jump when bits[31:26] = 6'b000010; jump target = bits[6:0]; bits[25:7] ignored.
REQ-015 SHALL apply per-cycle priority: reset > br_taken > halted > stall > jump > sequential.
REQ-016 br_taken: PC <= br_target; if_instr <= 32'h0; if_valid <= 0; if_pc, if_pc_plus1 hold; applies even while stall=1.
REQ-017 halted=1 (no br_taken): PC holds; if_instr <= 32'h0; if_valid <= 0.
REQ-018 stall=1 (no br_taken, not halted): PC, if_instr, if_pc, if_pc_plus1, if_valid all hold.
REQ-019 jump fetched (no stall/branch): if_instr <= imem_instr; if_pc <= PC; if_valid <= 1; PC <= jump target next cycle (one-cycle jump, no bubble).
REQ-020 sequential: if_instr <= imem_instr; if_pc <= PC; if_pc_plus1 <= PC+1; if_valid <= 1; PC <= PC+1.
REQ-021 SHALL wrap PC 127 -> 0 with no flag or error.
REQ-022 SHALL pass all-zero word (nop) through as a valid instruction; no special handling.
REQ-023 SHALL register all outputs except imem_addr; no combinational path from stall/br_taken to if_* outputs.

Reset
REQ-024 reset_n low SHALL immediately force PC=0, if_instr=32'h0, if_pc=0, if_pc_plus1=0, if_valid=0, halted=0, independent of clk.
REQ-025 On first rising edge after reset_n release SHALL fetch address 0 per REQ-020.
REQ-026 Reset asserted mid-stall, mid-jump or while halted SHALL discard all pending state; no redirect survives reset.

Configuration
REQ-027 Macro FETCH_HALT_DETECT_EN SHALL gate self-jump halt detection.
REQ-028 Defined: jump fetched whose target equals PC, accepted per REQ-019, SHALL set halted=1 on the same edge; halted clears only on reset or br_taken.
REQ-029 Not defined: halted SHALL be constant 0; self-jump refetches the same address every cycle with if_valid=1.

Verification
REQ-030 Reset release, memory 0..3 = nop, addi, lw, lw, no stall -> cycles 1..4 if_pc = 0,1,2,3, if_valid=1, if_pc_plus1 = 1,2,3,4.
REQ-031 Jump at address 12 with target 19 -> if_pc sequence 11,12,19,20; no invalid cycle.
REQ-032 stall=1 for 3 cycles while if_pc=5 -> if_pc, if_instr, imem_addr constant 5/6 for 3 cycles, then resumes at 6.
REQ-033 br_taken=1 with br_target=13 and stall=1 in the same cycle -> next cycle if_valid=0, if_instr=0, imem_addr=13; following cycle if_pc=13, if_valid=1.
REQ-034 With FETCH_HALT_DETECT_EN, j 38 at address 38 -> if_pc=38 valid one cycle, halted=1, then if_valid=0 indefinitely with imem_addr=38; without macro, if_pc=38 valid every cycle, halted=0.
REQ-035 Sequential run from address 126 -> if_pc 126,127,0 and if_pc_plus1 127,0,1; reset_n pulsed low mid-cycle -> all outputs 0 before next edge.
